// File: rtl/rns_to_bin_mrc_pkg.sv
// Shared types and modulus helpers for the RNS -> binary reverse converter.
// Moduli set {2^N, 2^N-1, 2^N+1}; the dynamic range is M = 2^N * (2^2N - 1).
package rns_to_bin_mrc_pkg;

   localparam int N_DEF = 8;

   typedef enum logic [2:0] {
      IDLE,
      V2,
      T3,
      U,
      DBL,
      ACC,
      OUT
   } conv_state_t;

   function automatic int m1_of(input int n);
      return 1 << n;
   endfunction

   function automatic int m2_of(input int n);
      return (1 << n) - 1;
   endfunction

   function automatic int m3_of(input int n);
      return (1 << n) + 1;
   endfunction

endpackage

// File: rtl/rns_to_bin_mrc_if.sv
// Residue-in / binary-out handshake bundle for the reverse converter.
//   in_valid/in_ready   : residue triple handshake (res_m1, res_m2, res_m3)
//   out_valid/out_ready : binary result handshake (out_bin)
// master = producer of residues / consumer of results, slave = converter.
interface rns_to_bin_mrc_if #(
   parameter int N = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     res_m1;
   logic [N-1:0]     res_m2;
   logic [N:0]       res_m3;
   logic             out_valid;
   logic             out_ready;
   logic [3*N-1:0]   out_bin;

   modport master (
      output in_valid, res_m1, res_m2, res_m3, out_ready,
      input  in_ready, out_valid, out_bin
   );

   modport slave (
      input  in_valid, res_m1, res_m2, res_m3, out_ready,
      output in_ready, out_valid, out_bin
   );
endinterface

// File: rtl/rns_to_bin_mrc_mod_sub.sv
// Combinational modular subtract y = (a - b) mod MOD.
//   a, b : W-bit operands, both already reduced to [0, MOD-1]
//   y    : W-bit result in [0, MOD-1]
// Because both operands are reduced, one conditional add of MOD is enough.
module rns_to_bin_mrc_mod_sub #(
   parameter int W   = 9,
   parameter int MOD = 257
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] y
);

   logic [W:0] diff;

   assign diff = {1'b0, a} - {1'b0, b};

   // On borrow the low W bits hold 2^W + (a-b); adding MOD wraps to a-b+MOD.
   assign y = diff[W] ? (diff[W-1:0] + W'(MOD)) : diff[W-1:0];

endmodule

// File: rtl/rns_to_bin_mrc.sv
// Sequential mixed-radix reverse converter, residues {2^N, 2^N-1, 2^N+1} -> binary.
//   clk   : system clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of rns_to_bin_mrc_if (residues in, binary out)
// One conversion in flight; result appears N+3 edges after acceptance.
//
// state | meaning
// IDLE  | in_ready high, capture and pre-reduce residues on in_valid
// V2    | v2 = (x2 - x1) mod m2
// T3    | acc = (v1 - x3) mod m3
// U     | acc = (acc - v2) mod m3, load doubling count
// DBL   | acc = 2*acc mod m3, N-1 times -> v3 = u * 2^(N-1) mod m3
// ACC   | out_bin = v1 + 2^N*v2 + 2^N*(2^N-1)*v3
// OUT   | out_valid high, hold until out_ready
module rns_to_bin_mrc
   import rns_to_bin_mrc_pkg::*;
#(
   parameter int N = N_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   rns_to_bin_mrc_if.slave    bus
);

   localparam int M2 = m2_of(N);
   localparam int M3 = m3_of(N);
   localparam int CW = (N > 2) ? $clog2(N) : 1;

   conv_state_t       state, state_nx;
   logic [N-1:0]      v1, x2_r;
   logic [N:0]        x3_r, v2, acc;
   logic [CW-1:0]     cnt;
   logic [3*N-1:0]    out_bin_r;

   logic [N:0]        v1_m2, v2_nx, sub3_a, sub3_b, acc_sub, acc_dbl;
   logic [N+1:0]      acc_x2;
   logic [3*N-1:0]    sum;
   logic              in_ready_c, out_valid_c;

   // x1 < 2^N, so x1 mod (2^N-1) only differs from x1 when x1 == 2^N-1.
   assign v1_m2 = (v1 == N'(M2)) ? '0 : {1'b0, v1};

   rns_to_bin_mrc_mod_sub #(.W(N+1), .MOD(M2)) u_sub_m2 (
      .a (({1'b0, x2_r})),
      .b (v1_m2),
      .y (v2_nx)
   );

   // The m3 subtractor is shared between T3 (v1 - x3) and U (t - v2).
   assign sub3_a = (state == T3) ? {1'b0, v1} : acc;
   assign sub3_b = (state == T3) ? x3_r       : v2;

   rns_to_bin_mrc_mod_sub #(.W(N+1), .MOD(M3)) u_sub_m3 (
      .a (sub3_a),
      .b (sub3_b),
      .y (acc_sub)
   );

   assign acc_x2  = {acc, 1'b0};
   assign acc_dbl = (acc_x2 >= (N+2)'(M3)) ? (N+1)'(acc_x2 - (N+2)'(M3)) : acc_x2[N:0];

   // 3N-bit wrapping arithmetic is exact: the true sum is < M < 2^3N.
   assign sum = (3*N)'(v1)
              + ((3*N)'(v2) << N)
              + (((3*N)'(acc) << (2*N)) - ((3*N)'(acc) << N));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      case (state)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) state_nx = V2;
         end
         V2:  state_nx = T3;
         T3:  state_nx = U;
         U:   state_nx = DBL;
         DBL: if (cnt == CW'(1)) state_nx = ACC;
         ACC: state_nx = OUT;
         OUT: begin
            out_valid_c = 1'b1;
            if (bus.out_ready) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1        <= '0;
         x2_r      <= '0;
         x3_r      <= '0;
         v2        <= '0;
         acc       <= '0;
         cnt       <= '0;
         out_bin_r <= '0;
      end else begin
         case (state)
            IDLE: if (bus.in_valid) begin
               v1   <= bus.res_m1;
               x2_r <= (bus.res_m2 == N'(M2)) ? '0 : bus.res_m2;
               x3_r <= (bus.res_m3 >= (N+1)'(M3)) ? bus.res_m3 - (N+1)'(M3) : bus.res_m3;
            end
            V2:  v2  <= v2_nx;
            T3:  acc <= acc_sub;
            U: begin
               acc <= acc_sub;
               cnt <= CW'(N-1);
            end
            DBL: begin
               acc <= acc_dbl;
               cnt <= cnt - CW'(1);
            end
            ACC: out_bin_r <= sum;
            default: ;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = out_valid_c;
   assign bus.out_bin   = out_bin_r;

endmodule
